// File: rtl/axis_rr_arbiter_if.sv
// Bundle of AXI4-Stream signals for NUM_PORTS parallel channels.
// Flattened buses carry channel i at [i*W +: W]; a single-channel instance is a plain stream port.
interface axis_rr_arbiter_if #(
    parameter int unsigned NUM_PORTS   = 1,
    parameter int unsigned TDATA_WIDTH = 8,
    parameter int unsigned TDEST_WIDTH = 8,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 8
);
    logic [NUM_PORTS-1:0]                 TVALID;
    logic [NUM_PORTS-1:0]                 TREADY;
    logic [NUM_PORTS*TDATA_WIDTH-1:0]     TDATA;
    logic [NUM_PORTS*TDATA_WIDTH/8-1:0]   TKEEP;
    logic [NUM_PORTS*TDATA_WIDTH/8-1:0]   TSTRB;
    logic [NUM_PORTS-1:0]                 TLAST;
    logic [NUM_PORTS*TID_WIDTH-1:0]       TID;
    logic [NUM_PORTS*TDEST_WIDTH-1:0]     TDEST;
    logic [NUM_PORTS*TUSER_WIDTH-1:0]     TUSER;

    modport master (
        output TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
        output TREADY
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-atomic round-robin arbiter: merges NUM_SRC AXI4-Stream sources onto one sink.
// The grant is locked from arbitration until the TLAST beat is accepted; the data path
// is a pure combinational mux, so only arbitration costs a cycle (one bubble per packet).
module axis_rr_arbiter #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned TDATA_WIDTH = 8,
    parameter int unsigned TDEST_WIDTH = 8,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 8,
    parameter int unsigned TAG_TID     = 0,
    localparam int unsigned GW         = $clog2(NUM_SRC)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axis_rr_arbiter_if.slave  S,
    axis_rr_arbiter_if.master M,
    output logic [GW-1:0]     GRANT,
    output logic              BUSY
);
    localparam int unsigned KW = TDATA_WIDTH / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef logic [GW:0] idx_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] ptr_q,   ptr_d;
    logic          sel_valid;
    logic          sel_last;
    logic          pkt_done;
    logic          found;
    idx_t          idx;

    assign sel_valid = S.TVALID[grant_q];
    assign sel_last  = S.TLAST[grant_q];
    assign pkt_done  = (state_q == LOCKED) && sel_valid && M.TREADY && sel_last;

    // State, grant and rotating-priority pointer registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: rotating search from the pointer in IDLE, release on accepted TLAST
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;
        case (state_q)
            IDLE: begin
                for (int unsigned k = 0; k < NUM_SRC; k++) begin
                    idx = {1'b0, ptr_q} + idx_t'(k);
                    if (idx >= idx_t'(NUM_SRC)) begin
                        idx = idx - idx_t'(NUM_SRC);
                    end
                    if (!found && S.TVALID[idx[GW-1:0]]) begin
                        found   = 1'b1;
                        grant_d = idx[GW-1:0];
                    end
                end
                if (found) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (pkt_done) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == GW'(NUM_SRC - 1)) ? '0 : grant_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: steer the granted source to the sink while locked, block everything otherwise
    always_comb begin
        S.TREADY = '0;
        M.TVALID = 1'b0;
        M.TDATA  = '0;
        M.TKEEP  = '0;
        M.TSTRB  = '0;
        M.TLAST  = 1'b0;
        M.TID    = '0;
        M.TDEST  = '0;
        M.TUSER  = '0;
        BUSY     = (state_q == LOCKED);
        GRANT    = grant_q;
        if (state_q == LOCKED) begin
            M.TVALID = sel_valid;
            M.TDATA  = S.TDATA[grant_q*TDATA_WIDTH +: TDATA_WIDTH];
            M.TKEEP  = S.TKEEP[grant_q*KW +: KW];
            M.TSTRB  = S.TSTRB[grant_q*KW +: KW];
            M.TLAST  = sel_last;
            M.TDEST  = S.TDEST[grant_q*TDEST_WIDTH +: TDEST_WIDTH];
            M.TUSER  = S.TUSER[grant_q*TUSER_WIDTH +: TUSER_WIDTH];
            if (TAG_TID != 0) begin
                M.TID = TID_WIDTH'(grant_q);
            end else begin
                M.TID = S.TID[grant_q*TID_WIDTH +: TID_WIDTH];
            end
            S.TREADY[grant_q] = M.TREADY;
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: directed packets per source, expected beats
// queued in hand-computed arbitration order, a negedge monitor pops and compares.
module tb_axis_rr_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned IW  = 8;
    localparam int unsigned DEW = 8;
    localparam int unsigned UW  = 1;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [7:0]  tid;
        int unsigned gap;
    } beat_t;

    typedef struct {
        logic [1:0] src;
        logic [7:0] data;
        logic       last;
        logic [7:0] tid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] grant, grant2;
    logic busy, busy2;

    always #5 clk = ~clk;

    axis_rr_arbiter_if #(.NUM_PORTS(N), .TDATA_WIDTH(DW), .TDEST_WIDTH(DEW), .TUSER_WIDTH(UW), .TID_WIDTH(IW)) s_if ();
    axis_rr_arbiter_if #(.NUM_PORTS(1), .TDATA_WIDTH(DW), .TDEST_WIDTH(DEW), .TUSER_WIDTH(UW), .TID_WIDTH(IW)) m_if ();
    axis_rr_arbiter_if #(.NUM_PORTS(N), .TDATA_WIDTH(DW), .TDEST_WIDTH(DEW), .TUSER_WIDTH(UW), .TID_WIDTH(IW)) s2_if ();
    axis_rr_arbiter_if #(.NUM_PORTS(1), .TDATA_WIDTH(DW), .TDEST_WIDTH(DEW), .TUSER_WIDTH(UW), .TID_WIDTH(IW)) m2_if ();

    axis_rr_arbiter #(
        .NUM_SRC(N), .TDATA_WIDTH(DW), .TDEST_WIDTH(DEW), .TUSER_WIDTH(UW), .TID_WIDTH(IW), .TAG_TID(0)
    ) u_dut (
        .ACLK(clk), .ARESETn(rst_n), .S(s_if), .M(m_if), .GRANT(grant), .BUSY(busy)
    );

    axis_rr_arbiter #(
        .NUM_SRC(N), .TDATA_WIDTH(DW), .TDEST_WIDTH(DEW), .TUSER_WIDTH(UW), .TID_WIDTH(IW), .TAG_TID(1)
    ) u_tag (
        .ACLK(clk), .ARESETn(rst_n), .S(s2_if), .M(m2_if), .GRANT(grant2), .BUSY(busy2)
    );

    assign s2_if.TVALID = s_if.TVALID;
    assign s2_if.TDATA  = s_if.TDATA;
    assign s2_if.TKEEP  = s_if.TKEEP;
    assign s2_if.TSTRB  = s_if.TSTRB;
    assign s2_if.TLAST  = s_if.TLAST;
    assign s2_if.TID    = s_if.TID;
    assign s2_if.TDEST  = s_if.TDEST;
    assign s2_if.TUSER  = s_if.TUSER;
    assign m2_if.TREADY = m_if.TREADY;

    beat_t          srcq[N][$];
    exp_t           exp_q[$];
    bit             rdy_q[$];
    logic [N-1:0]   hs_prev;
    int unsigned    n_pass = 0;
    int unsigned    n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add_beat(input int src, input logic [7:0] d, input logic last,
                            input logic [7:0] tid, input int unsigned gap);
        beat_t b;
        b.data = d; b.last = last; b.tid = tid; b.gap = gap;
        srcq[src].push_back(b);
    endtask

    task automatic expect_beat(input int src, input logic [7:0] d, input logic last, input logic [7:0] tid);
        exp_t e;
        e.src = 2'(src); e.data = d; e.last = last; e.tid = tid;
        exp_q.push_back(e);
    endtask

    function automatic bit all_done();
        bit d = (exp_q.size() == 0);
        for (int s = 0; s < N; s++) if (srcq[s].size() != 0) d = 0;
        return d;
    endfunction

    // One clock of source/sink stimulus; optionally pulses reset in the middle of the cycle.
    task automatic cycle(input bit rst_pulse);
        beat_t b;
        @(posedge clk);
        #1;
        for (int s = 0; s < N; s++)
            if (hs_prev[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
        for (int s = 0; s < N; s++) begin
            s_if.TVALID[s] = 1'b0;
            if (srcq[s].size() > 0) begin
                b = srcq[s][0];
                if (b.gap > 0) begin
                    b.gap--;
                    srcq[s][0] = b;
                end else begin
                    s_if.TVALID[s]       = 1'b1;
                    s_if.TDATA[s*8 +: 8] = b.data;
                    s_if.TLAST[s]        = b.last;
                    s_if.TID[s*8 +: 8]   = b.tid;
                end
            end
        end
        m_if.TREADY = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        if (rst_pulse) begin
            #1;
            check("t6_beat2_live", {m_if.TVALID, m_if.TDATA}, {1'b1, 8'h62});
            rst_n = 1'b0;
            s_if.TVALID = '0;
            #1;
            check("t6_rst_mvalid", m_if.TVALID, 0);
            check("t6_rst_tready", s_if.TREADY, 0);
            check("t6_rst_busy_grant", {busy, grant}, {1'b0, 2'd0});
            for (int s = 0; s < N; s++) srcq[s].delete();
            exp_q.delete();
            rdy_q.delete();
        end
        @(negedge clk);
        hs_prev = s_if.TVALID & s_if.TREADY;
    endtask

    task automatic run(input string name, input int unsigned budget, output int unsigned used);
        used = 0;
        do begin
            cycle(1'b0);
            used++;
        end while (!all_done() && used < budget);
        check({name, "_done"}, all_done(), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_if.TVALID = '0;
        m_if.TREADY = 1'b1;
        hs_prev = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {busy, busy2}, 2'b00);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: scoreboard compare on each accepted beat plus per-cycle handshake rules
    initial begin : monitor
        exp_t        e;
        logic        stall_prev;
        logic [29:0] held;
        logic [29:0] cur;
        logic [3:0]  mask;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                cur = {grant, m_if.TDATA, m_if.TLAST, m_if.TID, m_if.TDEST, m_if.TUSER, m_if.TKEEP, m_if.TSTRB};
                if (stall_prev) check("hold_stable", {m_if.TVALID, cur}, {1'b1, held});
                if (exp_q.size() > 0) begin
                    mask = 4'b0001 << exp_q[0].src;
                    check("tready_owner", (s_if.TREADY | s2_if.TREADY) & ~mask, 0);
                end else begin
                    check("tready_idle", s_if.TREADY | s2_if.TREADY, 0);
                end
                if (m_if.TVALID && m_if.TREADY) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_beat: got data 0x%0h from grant %0d, expected no beat", m_if.TDATA, grant);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", cur,
                              {e.src, e.data, e.last, e.tid, 8'h10 + 8'(e.src), e.src[0], 1'b1, e.src[1]});
                        check("tag_beat", {m2_if.TVALID, m2_if.TDATA, m2_if.TLAST, m2_if.TID},
                              {1'b1, e.data, e.last, 8'(e.src)});
                    end
                end
                stall_prev = m_if.TVALID && !m_if.TREADY;
                held = cur;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int unsigned used;
        hs_prev = '0;
        s_if.TVALID = '0; s_if.TDATA = '0; s_if.TLAST = '0; s_if.TID = '0;
        m_if.TREADY = 1'b1;
        for (int s = 0; s < N; s++) begin
            s_if.TDEST[s*8 +: 8] = 8'h10 + 8'(s);
            s_if.TUSER[s] = s[0];
            s_if.TKEEP[s] = 1'b1;
            s_if.TSTRB[s] = s[1];
        end

        // Reset with requests present: nothing may be accepted or presented
        rst_n = 1'b0;
        s_if.TVALID = 4'b0101;
        repeat (3) @(negedge clk);
        check("reset_mvalid", {m_if.TVALID, m2_if.TVALID}, 2'b00);
        check("reset_tready", s_if.TREADY, 0);
        check("reset_busy", {busy, busy2}, 2'b00);
        check("reset_grant", grant, 0);
        s_if.TVALID = '0;
        #1 rst_n = 1'b1;

        // T1: lone source 2, three beats, one-cycle arbitration latency
        add_beat(2, 8'hA1, 0, 8'h12, 0); add_beat(2, 8'hA2, 0, 8'h12, 0); add_beat(2, 8'hA3, 1, 8'h12, 0);
        expect_beat(2, 8'hA1, 0, 8'h12); expect_beat(2, 8'hA2, 0, 8'h12); expect_beat(2, 8'hA3, 1, 8'h12);
        run("t1", 20, used);
        check("t1_cycles", used, 5);
        check("t1_busy_after", busy, 0);

        // T1b: pointer now 3, so source 3 beats source 0
        add_beat(0, 8'h0B, 1, 8'h00, 0); add_beat(3, 8'h3B, 1, 8'h03, 0);
        expect_beat(3, 8'h3B, 1, 8'h03); expect_beat(0, 8'h0B, 1, 8'h00);
        run("t1b", 20, used);

        // T2: all sources, two 2-beat packets each, from reset
        do_reset();
        for (int s = 0; s < N; s++)
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 2; b++)
                    add_beat(s, 8'(s*16 + p*2 + b), b[0], 8'(s), 0);
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++)
                for (int b = 0; b < 2; b++)
                    expect_beat(s, 8'(s*16 + p*2 + b), b[0], 8'(s));
        run("t2", 60, used);
        check("t2_cycles", used, 25);

        // T3: source 1 locked with TREADY toggling; sources 0 and 2 arrive mid-packet
        for (int b = 0; b < 4; b++) add_beat(1, 8'(8'h31 + b), (b == 3), 8'h21, 0);
        add_beat(2, 8'h2C, 1, 8'h22, 2);
        add_beat(0, 8'h0C, 1, 8'h20, 2);
        rdy_q = '{1, 1, 0, 1, 0, 1, 0};
        for (int b = 0; b < 4; b++) expect_beat(1, 8'(8'h31 + b), (b == 3), 8'h21);
        expect_beat(2, 8'h2C, 1, 8'h22);
        expect_beat(0, 8'h0C, 1, 8'h20);
        run("t3", 40, used);
        check("t3_cycles", used, 13);

        // T4: granted source 3 goes quiet for 5 cycles while source 0 waits
        add_beat(3, 8'h41, 0, 8'h33, 0); add_beat(3, 8'h42, 0, 8'h33, 5); add_beat(3, 8'h43, 1, 8'h33, 0);
        add_beat(0, 8'h0D, 1, 8'h30, 1);
        expect_beat(3, 8'h41, 0, 8'h33); expect_beat(3, 8'h42, 0, 8'h33); expect_beat(3, 8'h43, 1, 8'h33);
        expect_beat(0, 8'h0D, 1, 8'h30);
        repeat (5) cycle(1'b0);
        check("t4_gap_busy_grant", {busy, grant}, {1'b1, 2'd3});
        run("t4", 30, used);
        check("t4_cycles", used, 7);

        // T5: S_TID 0x55 passes through on the plain instance, tagged instance shows index 2
        add_beat(2, 8'h51, 0, 8'h55, 0); add_beat(2, 8'h52, 1, 8'h55, 0);
        expect_beat(2, 8'h51, 0, 8'h55); expect_beat(2, 8'h52, 1, 8'h55);
        run("t5", 20, used);

        // T6: reset during beat 2 of a 4-beat packet, then pointer restarts at 0
        for (int b = 0; b < 4; b++) add_beat(1, 8'(8'h61 + b), (b == 3), 8'h41, 0);
        expect_beat(1, 8'h61, 0, 8'h41);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        #1 rst_n = 1'b1;
        add_beat(3, 8'h3E, 1, 8'h03, 0); add_beat(0, 8'h0E, 1, 8'h00, 0);
        expect_beat(0, 8'h0E, 1, 8'h00); expect_beat(3, 8'h3E, 1, 8'h03);
        run("t6", 20, used);
        check("t6_cycles", used, 5);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
